// File: rtl/dbg_pipeline_sequencer.sv
// Debug sequencer: owns pipeline enable, single-steps, and dumps the register file plus cycle count over valid/ready.
// Optional macro DBG_PC_DUMP_EN adds I_DBG_PC and a trailing PC word to each dump.
module dbg_pipeline_sequencer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_DBG_CMD_VALID,
  input  logic [1:0]        I_DBG_CMD,
  output logic              O_DBG_CMD_READY,
  input  logic              I_DBG_HALT_INSTR,
  output logic              O_DBG_PIPE_EN,
  output logic              O_DBG_RF_SEL,
  output logic [ADDR_W-1:0] O_DBG_RF_ADDR,
  input  logic [DATA_W-1:0] I_DBG_RF_DATA,
  output logic [DATA_W-1:0] O_DBG_TX_DATA,
  output logic              O_DBG_TX_VALID,
  input  logic              I_DBG_TX_READY,
  output logic              O_DBG_BUSY,
  output logic [2:0]        O_DBG_STATE,
  output logic [31:0]       O_DBG_CYCLE_CNT
`ifdef DBG_PC_DUMP_EN
  ,
  input  logic [31:0]       I_DBG_PC
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STEP     = 3'd2,
    DUMP_RD  = 3'd3,
    DUMP_TX  = 3'd4,
`ifdef DBG_PC_DUMP_EN
    DUMP_PC  = 3'd6,
`endif
    DUMP_CNT = 3'd5
  } state_t;

  localparam logic [1:0] CMD_HALT = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   tx_data;
  logic [31:0]         cycle_cnt;
  logic                cmd_ready;
  logic                cmd_accept;
  logic                pipe_en;
`ifdef DBG_PC_DUMP_EN
  logic [31:0]         pc_q;
`endif

  // Pipe enable is Mealy in RUN so a halt opcode in ID never advances.
  always_comb begin
    cmd_ready  = (state == IDLE) || (state == RUN);
    cmd_accept = I_DBG_CMD_VALID && cmd_ready;
    pipe_en    = (state == STEP) || ((state == RUN) && !I_DBG_HALT_INSTR);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      idx       <= '0;
      tx_data   <= '0;
      cycle_cnt <= '0;
`ifdef DBG_PC_DUMP_EN
      pc_q      <= '0;
`endif
    end else begin
      if (pipe_en) cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            case (I_DBG_CMD)
              CMD_RUN:  state <= RUN;
              CMD_STEP: state <= STEP;
              CMD_DUMP: begin
                state <= DUMP_RD;
                idx   <= '0;
              end
              default:  state <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (I_DBG_HALT_INSTR || (cmd_accept && (I_DBG_CMD == CMD_HALT))) state <= IDLE;
        end
        STEP: state <= IDLE;
        DUMP_RD: begin
          tx_data <= I_DBG_RF_DATA;
          state   <= DUMP_TX;
        end
        DUMP_TX: begin
          if (I_DBG_TX_READY) begin
            if (idx == LAST_IDX) begin
              tx_data <= DATA_W'(cycle_cnt);
`ifdef DBG_PC_DUMP_EN
              pc_q    <= I_DBG_PC;
`endif
              state   <= DUMP_CNT;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= DUMP_RD;
            end
          end
        end
        DUMP_CNT: begin
          if (I_DBG_TX_READY) begin
`ifdef DBG_PC_DUMP_EN
            tx_data <= DATA_W'(pc_q);
            state   <= DUMP_PC;
`else
            idx     <= '0;
            state   <= IDLE;
`endif
          end
        end
`ifdef DBG_PC_DUMP_EN
        DUMP_PC: begin
          if (I_DBG_TX_READY) begin
            idx   <= '0;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign O_DBG_CMD_READY = cmd_ready;
  assign O_DBG_PIPE_EN   = pipe_en;
  assign O_DBG_RF_SEL    = (state == DUMP_RD) || (state == DUMP_TX);
  assign O_DBG_RF_ADDR   = idx;
  assign O_DBG_TX_DATA   = tx_data;
`ifdef DBG_PC_DUMP_EN
  assign O_DBG_TX_VALID  = (state == DUMP_TX) || (state == DUMP_CNT) || (state == DUMP_PC);
`else
  assign O_DBG_TX_VALID  = (state == DUMP_TX) || (state == DUMP_CNT);
`endif
  assign O_DBG_BUSY      = (state != IDLE);
  assign O_DBG_STATE     = state;
  assign O_DBG_CYCLE_CNT = cycle_cnt;

endmodule

// File: doc/dbg_pipeline_sequencer.md
Name: dbg_pipeline_sequencer

Overview:
- Debug sequencer that owns the pipeline enable and time-shares the register-file read port between the ID stage and the debug path.
- Runs the MIPS pipeline freely or one cycle at a time.
- When halted, walks all registers through the debug read port and streams them out over a valid/ready link. The stream is followed by the executed-cycle count.
- Sits between the debug command interface (UART front end) and the pipeline top.

Parameters:
- NUM_REGS, 32, number of register-file entries dumped.
- ADDR_W, 5, register address width.
- DATA_W, 32, register and stream word width.

Ports:
- CLK  in  1  system clock, single clock domain.
- RESET  in  1  synchronous, active-high reset.
- I_DBG_CMD_VALID  in  1  command strobe.
- I_DBG_CMD  in  2  command code: 00 HALT, 01 RUN, 10 STEP, 11 DUMP.
- O_DBG_CMD_READY  out  1  command accepted when VALID and READY are both high.
- I_DBG_HALT_INSTR  in  1  pipeline reports a halt opcode in ID.
- O_DBG_PIPE_EN  out  1  pipeline register and PC advance enable.
- O_DBG_RF_SEL  out  1  1 = register-file read address taken from O_DBG_RF_ADDR.
- O_DBG_RF_ADDR  out  ADDR_W  debug read address.
- I_DBG_RF_DATA  in  DATA_W  register-file read data, combinational from the address.
- O_DBG_TX_DATA  out  DATA_W  stream word.
- O_DBG_TX_VALID  out  1  stream word valid.
- I_DBG_TX_READY  in  1  sink ready.
- O_DBG_BUSY  out  1  high in any state other than IDLE.
- O_DBG_STATE  out  3  current state encoding, for visibility.
- O_DBG_CYCLE_CNT  out  32  count of enabled pipeline cycles.

Behaviour:
- Reset: synchronous reset of all registers.
  - State is IDLE; index, TX_DATA and CYCLE_CNT are 0.
  - TX_VALID, RF_SEL and PIPE_EN are 0; CMD_READY is 1.
  - Reset asserted mid-run or mid-dump aborts at that edge. There is no partial-word completion.
- States and encodings: IDLE=0, RUN=1, STEP=2, DUMP_RD=3, DUMP_TX=4, DUMP_CNT=5.
- IDLE:
  - PIPE_EN=0 and CMD_READY=1.
  - On an accepted command: RUN goes to RUN, STEP goes to STEP, DUMP goes to DUMP_RD with index=0, HALT stays in IDLE.
  - I_DBG_HALT_INSTR is ignored in IDLE.
- RUN:
  - PIPE_EN = !I_DBG_HALT_INSTR; this is a Mealy term, so the halt instruction never advances.
  - On HALT_INSTR=1, the next state is IDLE.
  - CMD_READY=1. An accepted HALT goes to IDLE, with PIPE_EN still high in the accept cycle. Other codes are accepted and dropped.
  - If HALT_INSTR and a HALT command occur together, the next state is IDLE and PIPE_EN=0.
- STEP:
  - PIPE_EN=1 for exactly one cycle regardless of HALT_INSTR, then IDLE.
  - CMD_READY=0.
- CYCLE_CNT increments on every cycle with PIPE_EN=1 and wraps 0xFFFFFFFF to 0. It is cleared only by reset.
- DUMP_RD:
  - RF_SEL=1 and RF_ADDR=index.
  - I_DBG_RF_DATA is registered into TX_DATA at the clock edge, then the state moves to DUMP_TX.
  - Exactly one cycle long.
- DUMP_TX:
  - RF_SEL=1, TX_VALID=1.
  - TX_DATA and RF_ADDR stay stable until READY.
  - On VALID and READY: if index==NUM_REGS-1, load TX_DATA=CYCLE_CNT and go to DUMP_CNT; otherwise index+1 and go to DUMP_RD.
  - TX_VALID drops for the DUMP_RD cycle, so each register takes at least 2 cycles.
- DUMP_CNT:
  - TX_VALID=1 and RF_SEL=0.
  - On READY, go to IDLE with index=0.
- CMD_READY=0 throughout all dump states.
- PIPE_EN=0 in the dump states, so no register writes collide with dump reads.
- The dump sends NUM_REGS+1 words, in the order r0..r31 then CYCLE_CNT.
- READY held low indefinitely stalls the dump in place with no data change.

Optional Feature:
- Macro: DBG_PC_DUMP_EN.
- When defined:
  - Adds input I_DBG_PC (32 bits).
  - Adds state DUMP_PC (encoding 6) after DUMP_CNT, which sends the PC sampled on entry to DUMP_CNT.
  - A dump is NUM_REGS+2 words.
- When undefined: no port, no state, and the dump ends after the CYCLE_CNT word.

Test Plan:
- RESET high for 2 cycles with VALID=1 and CMD=01 -> state stays 0, PIPE_EN=0, TX_VALID=0, CYCLE_CNT=0 after release.
- STEP issued 3 times from IDLE -> PIPE_EN high for exactly 3 isolated cycles, CYCLE_CNT=3, CMD_READY low in each STEP cycle.
- RUN, then HALT_INSTR raised on the 10th RUN cycle -> PIPE_EN high for 9 cycles, low on the 10th, state=IDLE next, CYCLE_CNT=9.
- DUMP with RF modeled as reg[i]=i*4 and TX_READY=1 -> 33 words 0,4,...,124 then CYCLE_CNT. RF_ADDR goes 0..31, and 66 cycles elapse from accept to IDLE.
- DUMP with TX_READY toggled randomly, held low for 20 cycles on word 7 -> TX_DATA=28 stable throughout, no word lost or duplicated.
- RESET during DUMP_TX of word 12 -> next cycle TX_VALID=0, RF_SEL=0, state IDLE. A following DUMP restarts at r0.
